// File: rtl/ext_code_seq_param.sv
// External-trigger code sequencer: a DEPTH-entry code table replayed one entry per trigger pulse.
// Define EXT_CODE_READBACK_EN to add the registered table read port (iRD_ADDR / oRD_DATA).
module ext_code_seq_param #(
    parameter int  CODE_W = 32,
    parameter int  DEPTH  = 16,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iSET_CODE_FLAG,
    input  logic [CODE_W-1:0] iSET_CODE,
    input  logic              iSET_WADDR_FLAG,
    input  logic [IDX_W-1:0]  iSET_WADDR,
    input  logic              iSET_INDEX_FLAG,
    input  logic [IDX_W-1:0]  iSET_INDEX,
    input  logic              iSET_LEN_FLAG,
    input  logic [IDX_W:0]    iSET_LEN,
    input  logic              iLoop,
    input  logic              iTrigger,
    output logic [CODE_W-1:0] oCode,
    output logic [IDX_W-1:0]  oIndex,
    output logic              oActive,
    output logic              oDone,
    output logic              oCfgErr
`ifdef EXT_CODE_READBACK_EN
    ,
    input  logic [IDX_W-1:0]  iRD_ADDR,
    output logic [CODE_W-1:0] oRD_DATA
`endif
);

    localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_OUT, S_DONE} state_e;

    logic [CODE_W-1:0] table_q [DEPTH];
    logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d, wr_addr;
    logic [IDX_W:0]    len_q, len_d, new_len;
    logic [IDX_W-1:0]  index_q, index_d;
    state_e            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              active_q, active_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;
    logic              hold_q, hold_d;
    logic              trg_meta_q, trg_s_q, trg_d_q;
    logic              rise, fall;

    // Synchroniser and edge detector reset to "high seen" so a trigger held across reset is not a rise.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            trg_meta_q <= 1'b1;
            trg_s_q    <= 1'b1;
            trg_d_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value of its source.
            trg_meta_q <= iTrigger;
            trg_s_q    <= trg_meta_q;
            trg_d_q    <= trg_s_q;
        end
    end

    assign rise = trg_s_q & ~trg_d_q;
    assign fall = ~trg_s_q & trg_d_q;

    // A same-cycle address load redirects the write and the pointer continues after it.
    assign wr_addr = iSET_WADDR_FLAG ? iSET_WADDR : wr_ptr_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (iSET_CODE_FLAG) begin
            wr_ptr_d = wr_addr + IDX_W'(1);
        end else if (iSET_WADDR_FLAG) begin
            wr_ptr_d = iSET_WADDR;
        end
    end

    // NOTE: the table is reset explicitly because every entry must read as 0 after reset.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else if (iSET_CODE_FLAG) begin
            table_q[wr_addr] <= iSET_CODE;
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves a latch behind.
        new_len   = (iSET_LEN == '0 || iSET_LEN > LEN_MAX) ? LEN_MAX : iSET_LEN;
        state_d   = state_q;
        index_d   = index_q;
        code_d    = code_q;
        active_d  = active_q;
        done_d    = done_q;
        cfg_err_d = cfg_err_q;
        hold_d    = hold_q;
        len_d     = len_q;

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d  = S_OUT;
                    code_d   = table_q[index_q];
                    active_d = 1'b1;
                end
            end
            S_OUT: begin
                if (fall) begin
                    state_d  = S_IDLE;
                    code_d   = '0;
                    active_d = 1'b0;
                    hold_d   = 1'b0;
                    if (!hold_q) begin
                        if (({1'b0, index_q} + (IDX_W+1)'(1)) < len_q) begin
                            index_d = index_q + IDX_W'(1);
                        end else if (iLoop) begin
                            index_d = '0;
                        end else begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                // Rises are ignored until the host reloads the play index.
            end
            default: state_d = S_IDLE;
        endcase

        // Host index load overrides the advance; a load during a pulse pins the index for its fall.
        if (iSET_INDEX_FLAG) begin
            if ({1'b0, iSET_INDEX} >= len_q) begin
                cfg_err_d = 1'b1;
            end else begin
                index_d = iSET_INDEX;
                done_d  = 1'b0;
                if (state_d == S_DONE) state_d = S_IDLE;
                if (state_d == S_OUT)  hold_d  = 1'b1;
            end
        end

        if (iSET_LEN_FLAG) begin
            len_d = new_len;
            if ({1'b0, index_d} >= new_len) index_d = '0;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q   <= S_IDLE;
            index_q   <= '0;
            code_q    <= '0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            hold_q    <= 1'b0;
            len_q     <= LEN_MAX;
            wr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            code_q    <= code_d;
            active_q  <= active_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
            hold_q    <= hold_d;
            len_q     <= len_d;
            wr_ptr_q  <= wr_ptr_d;
        end
    end

    assign oCode   = code_q;
    assign oIndex  = index_q;
    assign oActive = active_q;
    assign oDone   = done_q;
    assign oCfgErr = cfg_err_q;

`ifdef EXT_CODE_READBACK_EN
    logic [CODE_W-1:0] rd_data_q;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= table_q[iRD_ADDR];
        end
    end

    assign oRD_DATA = rd_data_q;
`endif

endmodule
